// File: rtl/io_po_bank.sv
// io_po_bank: multi-channel fabric-to-pad output tile with per-channel mode, scan-chained output flops
// and a complement-checked config pair. Define IO_PO_BANK_PIPE_EN for a second, non-scanned pad stage.
module io_po_bank #(
    parameter int                NUM_CH  = 4,
    parameter logic [NUM_CH-1:0] RST_VAL = '0
) (
    input  logic                  io_po_clk,
    input  logic                  io_po_reset,
    input  logic [NUM_CH-1:0]     io_po_f2a_i,
    input  logic                  io_po_se,
    input  logic                  io_po_sc_in,
    input  logic [2*NUM_CH-1:0]   feedthrough_mem_in,
    input  logic [2*NUM_CH-1:0]   feedthrough_mem_inb,
    output logic [NUM_CH-1:0]     gfpga_pad_poutput_F2A,
    output logic                  io_po_sc_out,
    output logic                  io_po_cfg_err
);

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'b00,
        MODE_REG    = 2'b01,
        MODE_TOGGLE = 2'b10,
        MODE_TIE    = 2'b11
    } mode_e;

    mode_e             mode   [NUM_CH];
    logic [NUM_CH-1:0] fault;
    logic [NUM_CH-1:0] q;
    logic [NUM_CH-1:0] q_next;
    logic [NUM_CH-1:0] stage;

    // A config bit is trusted only when it differs from its complement.
    always_comb begin
        fault = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            mode[i]  = mode_e'({feedthrough_mem_in[2*i+1], feedthrough_mem_in[2*i]});
            fault[i] = (feedthrough_mem_in[2*i]   == feedthrough_mem_inb[2*i]) ||
                       (feedthrough_mem_in[2*i+1] == feedthrough_mem_inb[2*i+1]);
        end
    end

    always_comb begin
        q_next = q;
        if (io_po_se) begin
            q_next[0] = io_po_sc_in;
            for (int i = 1; i < NUM_CH; i++) begin
                q_next[i] = q[i-1];
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                case (mode[i])
                    MODE_BYPASS, MODE_REG: q_next[i] = io_po_f2a_i[i];
                    MODE_TOGGLE:           q_next[i] = q[i] ^ io_po_f2a_i[i];
                    default:               q_next[i] = q[i];
                endcase
            end
        end
    end

    always_ff @(posedge io_po_clk or posedge io_po_reset) begin
        if (io_po_reset) begin
            q             <= RST_VAL;
            io_po_cfg_err <= 1'b0;
        end else begin
            q             <= q_next;
            io_po_cfg_err <= io_po_cfg_err | (|fault);
        end
    end

`ifdef IO_PO_BANK_PIPE_EN
    logic [NUM_CH-1:0] p;

    always_ff @(posedge io_po_clk or posedge io_po_reset) begin
        if (io_po_reset) begin
            p <= RST_VAL;
        end else begin
            p <= q;
        end
    end

    assign stage = p;
`else
    assign stage = q;
`endif

    // Fault forcing wins over every mode, including BYPASS.
    always_comb begin
        gfpga_pad_poutput_F2A = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (fault[i]) begin
                gfpga_pad_poutput_F2A[i] = RST_VAL[i];
            end else if (mode[i] == MODE_BYPASS) begin
                gfpga_pad_poutput_F2A[i] = io_po_f2a_i[i];
            end else begin
                gfpga_pad_poutput_F2A[i] = stage[i];
            end
        end
    end

    assign io_po_sc_out = q[NUM_CH-1];

endmodule

// File: tb/tb_io_po_bank.sv
// tb_io_po_bank: directed and randomized checks of io_po_bank against a per-cycle behavioural model.
// Follows IO_PO_BANK_PIPE_EN when the bench is built with it.
module tb_io_po_bank;

    localparam int         N  = 4;
    localparam logic [3:0] RV = 4'b1010;

    logic         clk;
    logic         rst;
    logic [N-1:0] f2a;
    logic         se;
    logic         sc_in;
    logic [2*N-1:0] mem_in;
    logic [2*N-1:0] mem_inb;
    logic [N-1:0] pads;
    logic         sc_out;
    logic         cfg_err;

    int errors = 0;
    int checks = 0;

    // Model state: main output flops, optional pipe stage, sticky error.
    logic [N-1:0] mq;
    logic [N-1:0] mp;
    logic         merr;

    io_po_bank #(.NUM_CH(N), .RST_VAL(RV)) dut (
        .io_po_clk             (clk),
        .io_po_reset           (rst),
        .io_po_f2a_i           (f2a),
        .io_po_se              (se),
        .io_po_sc_in           (sc_in),
        .feedthrough_mem_in    (mem_in),
        .feedthrough_mem_inb   (mem_inb),
        .gfpga_pad_poutput_F2A (pads),
        .io_po_sc_out          (sc_out),
        .io_po_cfg_err         (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [1:0] mode_of(input int i);
        return {mem_in[2*i+1], mem_in[2*i]};
    endfunction

    function automatic logic bad_ch(input int i);
        return (mem_in[2*i] == mem_inb[2*i]) || (mem_in[2*i+1] == mem_inb[2*i+1]);
    endfunction

    function automatic logic [N-1:0] exp_pads();
        logic [N-1:0] r;
        logic [N-1:0] shown;
`ifdef IO_PO_BANK_PIPE_EN
        shown = mp;
`else
        shown = mq;
`endif
        for (int i = 0; i < N; i++) begin
            if (bad_ch(i))             r[i] = RV[i];
            else if (mode_of(i) == 0)  r[i] = f2a[i];
            else                       r[i] = shown[i];
        end
        return r;
    endfunction

    task automatic model_reset();
        mq   = RV;
        mp   = RV;
        merr = 1'b0;
    endtask

    // Advance one clock, stepping the model with the inputs held across the edge.
    task automatic tick();
        logic [N-1:0] nq;
        logic         anyf;
        @(posedge clk);
        if (!rst) begin
            nq   = mq;
            anyf = 1'b0;
            for (int i = 0; i < N; i++) anyf = anyf | bad_ch(i);
            if (se) begin
                for (int i = N - 1; i > 0; i--) nq[i] = mq[i-1];
                nq[0] = sc_in;
            end else begin
                for (int i = 0; i < N; i++) begin
                    case (mode_of(i))
                        2'd0, 2'd1: nq[i] = f2a[i];
                        2'd2:       nq[i] = mq[i] ^ f2a[i];
                        default:    nq[i] = mq[i];
                    endcase
                end
            end
            merr = merr | anyf;
            mp   = mq;
            mq   = nq;
        end
        #1;
    endtask

    task automatic set_cfg(input logic [2*N-1:0] m);
        mem_in  = m;
        mem_inb = ~m;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #2;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        set_cfg(8'h55);
        f2a = '0; se = 1'b0; sc_in = 1'b0;
        rst = 1'b1;
        model_reset();
        #3;
        checks++;
        if (pads !== 4'b1010) begin errors++; $display("[TB] FAIL reset_pads: got %b want %b", pads, 4'b1010); end
        checks++;
        if (sc_out !== 1'b1) begin errors++; $display("[TB] FAIL reset_sc_out: got %b want 1", sc_out); end
        checks++;
        if (cfg_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_cfg_err: got %b want 0", cfg_err); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (pads !== 4'b1010) begin errors++; $display("[TB] FAIL post_reset_pads: got %b want %b", pads, 4'b1010); end
        checks++;
        if (cfg_err !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_cfg_err: got %b want 0", cfg_err); end
    endtask

    task automatic test_reg();
        set_cfg(8'h55);
        f2a = 4'b0101;
        #1;
        checks++;
        if (pads !== exp_pads()) begin errors++; $display("[TB] FAIL reg_before_edge: got %b want %b", pads, exp_pads()); end
        tick();
`ifdef IO_PO_BANK_PIPE_EN
        checks++;
        if (pads !== exp_pads()) begin errors++; $display("[TB] FAIL reg_pipe_mid: got %b want %b", pads, exp_pads()); end
        tick();
`endif
        checks++;
        if (pads !== 4'b0101) begin errors++; $display("[TB] FAIL reg_latency: got %b want %b", pads, 4'b0101); end
        set_cfg(8'b01_00_01_01);
        f2a = 4'b0100;
        #1;
        checks++;
        if (pads[2] !== 1'b1) begin errors++; $display("[TB] FAIL bypass_rise: got %b want 1", pads[2]); end
        checks++;
        if (pads !== exp_pads()) begin errors++; $display("[TB] FAIL bypass_pads: got %b want %b", pads, exp_pads()); end
        f2a = 4'b0000;
        #1;
        checks++;
        if (pads[2] !== 1'b0) begin errors++; $display("[TB] FAIL bypass_fall: got %b want 0", pads[2]); end
        tick();
    endtask

    task automatic test_toggle();
        do_reset();
        set_cfg(8'b01_01_01_10);
        f2a = '0;
        for (int k = 0; k < 3; k++) begin
            f2a = 4'b0001;
            tick();
            checks++;
            if (pads !== exp_pads()) begin errors++; $display("[TB] FAIL toggle_pulse%0d: got %b want %b", k, pads, exp_pads()); end
            f2a = 4'b0000;
            tick();
            checks++;
            if (pads !== exp_pads()) begin errors++; $display("[TB] FAIL toggle_idle%0d: got %b want %b", k, pads, exp_pads()); end
        end
        tick();
        checks++;
        if (pads[0] !== 1'b1) begin errors++; $display("[TB] FAIL toggle_final: got %b want 1", pads[0]); end
    endtask

    task automatic test_scan();
        logic [3:0] bits;
        logic [3:0] want_out;
        bits     = 4'b1101;
        want_out = 4'b1010;
        do_reset();
        set_cfg(8'h55);
        f2a = '0;
        se  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sc_in = bits[k];
            tick();
            checks++;
            if (sc_out !== want_out[k]) begin errors++; $display("[TB] FAIL scan_out%0d: got %b want %b", k, sc_out, want_out[k]); end
            checks++;
            if (pads !== exp_pads()) begin errors++; $display("[TB] FAIL scan_pads%0d: got %b want %b", k, pads, exp_pads()); end
        end
`ifndef IO_PO_BANK_PIPE_EN
        checks++;
        if (pads !== 4'b1011) begin errors++; $display("[TB] FAIL scan_final_q: got %b want %b", pads, 4'b1011); end
`endif
        se = 1'b0;
    endtask

    task automatic test_fault();
        do_reset();
        set_cfg(8'h55);
        f2a = '0;
        tick();
        mem_inb[2] = 1'b1;
        #1;
        checks++;
        if (pads[1] !== RV[1]) begin errors++; $display("[TB] FAIL fault_force: got %b want %b", pads[1], RV[1]); end
        checks++;
        if (cfg_err !== 1'b0) begin errors++; $display("[TB] FAIL fault_err_early: got %b want 0", cfg_err); end
        se = 1'b1; sc_in = 1'b1;
        tick();
        checks++;
        if (cfg_err !== 1'b1) begin errors++; $display("[TB] FAIL fault_err_set: got %b want 1", cfg_err); end
        checks++;
        if (sc_out !== mq[N-1]) begin errors++; $display("[TB] FAIL fault_scan: got %b want %b", sc_out, mq[N-1]); end
        se = 1'b0;
        set_cfg(8'h55);
        tick();
        tick();
        checks++;
        if (cfg_err !== 1'b1) begin errors++; $display("[TB] FAIL fault_sticky: got %b want 1", cfg_err); end
        checks++;
        if (pads !== exp_pads()) begin errors++; $display("[TB] FAIL fault_fixed_pads: got %b want %b", pads, exp_pads()); end
        do_reset();
        checks++;
        if (cfg_err !== 1'b0) begin errors++; $display("[TB] FAIL fault_clear: got %b want 0", cfg_err); end
    endtask

    task automatic test_reset_mid_shift();
        do_reset();
        set_cfg(8'h55);
        se = 1'b1; sc_in = 1'b1;
        tick();
        tick();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (sc_out !== RV[N-1]) begin errors++; $display("[TB] FAIL midshift_sc_out: got %b want %b", sc_out, RV[N-1]); end
        checks++;
        if (pads !== RV) begin errors++; $display("[TB] FAIL midshift_pads: got %b want %b", pads, RV); end
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sc_in = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if (sc_out !== mq[N-1]) begin errors++; $display("[TB] FAIL resume_sc_out%0d: got %b want %b", k, sc_out, mq[N-1]); end
            checks++;
            if (pads !== exp_pads()) begin errors++; $display("[TB] FAIL resume_pads%0d: got %b want %b", k, pads, exp_pads()); end
        end
        se = 1'b0;
    endtask

    task automatic test_random();
        logic [2*N-1:0] m;
        do_reset();
        for (int c = 0; c < 300; c++) begin
            if ($urandom_range(0, 9) == 0) begin
                m = 8'($urandom);
                set_cfg(m);
                if (c > 250 && $urandom_range(0, 3) == 0) mem_inb[$urandom_range(0, 2*N-1)] ^= 1'b1;
            end
            f2a   = 4'($urandom);
            se    = ($urandom_range(0, 3) == 0);
            sc_in = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (pads !== exp_pads()) begin errors++; $display("[TB] FAIL rand_pads c=%0d: got %b want %b", c, pads, exp_pads()); end
            checks++;
            if (sc_out !== mq[N-1]) begin errors++; $display("[TB] FAIL rand_sc_out c=%0d: got %b want %b", c, sc_out, mq[N-1]); end
            checks++;
            if (cfg_err !== merr) begin errors++; $display("[TB] FAIL rand_cfg_err c=%0d: got %b want %b", c, cfg_err, merr); end
            tick();
        end
        se = 1'b0;
    endtask

    initial begin
        test_reset();
        test_reg();
        test_toggle();
        test_scan();
        test_fault();
        test_reset_mid_shift();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
